// File: rtl/rx_ctrl.sv
// Receive-channel controller: acknowledges a host transfer, forwards frame beats
// through a one-deep output register, and reports good or oversize frames.
module rx_ctrl #(
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        CHNL_RX_CLK,
  input  logic        CHNL_RX,
  output logic        CHNL_RX_ACK,
  input  logic        CHNL_RX_LAST,
  input  logic [31:0] CHNL_RX_LEN,
  input  logic [30:0] CHNL_RX_OFF,
  input  logic [63:0] CHNL_RX_DATA,
  input  logic        CHNL_RX_DATA_VALID,
  output logic        CHNL_RX_DATA_REN,
  output logic [63:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_LAST,
  output logic        FRAME_END,
  output logic        FRAME_ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACK      = 3'd1,
    RECV     = 3'd2,
    FLUSH    = 3'd3,
    DONE     = 3'd4,
    WAIT_LOW = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] len_r;
  logic        len_err_r;
  logic [31:0] beat_cnt_r;
  logic [31:0] beats_s;
  logic        ren_s;
  logic        accept_s;
  logic        load_s;
  logic        last_beat_s;
  logic        ack_r;
  logic        frame_end_r;
  logic        frame_err_r;
  logic [63:0] out_data_r;
  logic        out_valid_r;
  logic        out_last_r;
  logic        unused_s;

  assign CHNL_RX_CLK = CLK;
  assign unused_s    = ^{CHNL_RX_LAST, CHNL_RX_OFF};

  // Beat count is ceil(len/2) without a 33rd bit: 0xFFFFFFFF gives 0x80000000.
  assign beats_s     = {1'b0, len_r[31:1]} + {31'd0, len_r[0]};
  assign last_beat_s = (beat_cnt_r == (beats_s - 32'd1));
  assign accept_s    = CHNL_RX_DATA_VALID & ren_s;
  assign load_s      = accept_s & ~len_err_r;

  // Read enable: only in RECV, and only when the output register can take a beat.
  always_comb begin
    ren_s = 1'b0;
    if (state_r == RECV) begin
      ren_s = len_err_r | ~out_valid_r | OUT_READY;
    end else begin
      ren_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (CHNL_RX) state_s = ACK;
        else         state_s = IDLE;
      end
      ACK: begin
        if (len_r == 32'd0) state_s = DONE;
        else                state_s = RECV;
      end
      RECV: begin
        if (accept_s && last_beat_s) state_s = FLUSH;
        else                         state_s = RECV;
      end
      FLUSH: begin
        if (!out_valid_r) state_s = DONE;
        else              state_s = FLUSH;
      end
      DONE: begin
        state_s = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!CHNL_RX) state_s = IDLE;
        else          state_s = WAIT_LOW;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, frame bookkeeping and status pulses.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      len_r       <= 32'd0;
      len_err_r   <= 1'b0;
      beat_cnt_r  <= 32'd0;
      ack_r       <= 1'b0;
      frame_end_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ack_r       <= (state_s == ACK);
      frame_end_r <= (state_r == DONE) & ~len_err_r;
      frame_err_r <= (state_r == DONE) & len_err_r;
      if ((state_r == IDLE) && CHNL_RX) begin
        len_r      <= CHNL_RX_LEN;
        len_err_r  <= (CHNL_RX_LEN > 32'(MAX_WORDS));
        beat_cnt_r <= 32'd0;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + 32'd1;
      end
    end
  end

  // Output register: a new load wins over draining the current beat.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_data_r  <= 64'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= CHNL_RX_DATA;
      out_valid_r <= 1'b1;
      out_last_r  <= last_beat_s;
    end else if (out_valid_r && OUT_READY) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign CHNL_RX_ACK      = ack_r;
  assign CHNL_RX_DATA_REN = ren_s;
  assign OUT_DATA         = out_data_r;
  assign OUT_VALID        = out_valid_r;
  assign OUT_LAST         = out_last_r;
  assign FRAME_END        = frame_end_r;
  assign FRAME_ERR        = frame_err_r;

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed, table-driven bench for rx_ctrl: whole-frame scenarios plus
// hand-written reset and held-request sequences.
module tb_rx_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CHNL_RX_CLK;
  logic        CHNL_RX;
  logic        CHNL_RX_ACK;
  logic        CHNL_RX_LAST;
  logic [31:0] CHNL_RX_LEN;
  logic [30:0] CHNL_RX_OFF;
  logic [63:0] CHNL_RX_DATA;
  logic        CHNL_RX_DATA_VALID;
  logic        CHNL_RX_DATA_REN;
  logic [63:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_LAST;
  logic        FRAME_END;
  logic        FRAME_ERR;

  rx_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .CHNL_RX_CLK(CHNL_RX_CLK), .CHNL_RX(CHNL_RX),
    .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_LAST(CHNL_RX_LAST), .CHNL_RX_LEN(CHNL_RX_LEN),
    .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_LAST(OUT_LAST), .FRAME_END(FRAME_END), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] len;
    int          mode;       // 0: ready high, 1: ready toggles, 2: ready random
    bit          hold;       // keep CHNL_RX high through and past completion
    int          exp_beats;  // ceil(len/2)
    int          exp_end;
    int          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word(input int i);
    return {32'hC0DE0000 + 32'(2 * i + 1), 32'hC0DE0000 + 32'(2 * i)};
  endfunction

  task automatic run_frame(input vec_t v);
    int cyc = 0, acks = 0, acc = 0, outs = 0, ends = 0, errs = 0, tail = 0;
    int ack_cyc = -1, end_cyc = -1, leave_cyc = -1, budget;
    bit ack_prev = 0, pend = 0, done = 0, err_f, in_recv, exp_ren;
    logic [63:0] pend_word = 64'd0;
    err_f  = (v.len > 32'd4096);
    budget = 4 * v.exp_beats + 60;
    CHNL_RX = 1'b0;
    repeat (2) @(negedge CLK);
    while (!done) begin
      @(negedge CLK);
      CHNL_RX            = (acks == 0) || v.hold;
      CHNL_RX_LEN        = v.len;
      CHNL_RX_DATA       = word(acc);
      CHNL_RX_DATA_VALID = 1'b1;
      case (v.mode)
        0:       OUT_READY = 1'b1;
        1:       OUT_READY = (cyc % 2 == 0);
        default: OUT_READY = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (pend) begin
        chk("latency_valid", OUT_VALID, 1'b1);
        chk("latency_data", OUT_DATA, pend_word);
        pend = 0;
      end
      if (CHNL_RX_ACK) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = cyc;
      end
      if (FRAME_END) begin
        ends++;
        if (end_cyc < 0) end_cyc = cyc;
      end
      if (FRAME_ERR) errs++;
      in_recv = ack_prev && (acc < v.exp_beats);
      exp_ren = in_recv && (err_f || !OUT_VALID || OUT_READY);
      chk("ren", CHNL_RX_DATA_REN, exp_ren);
      if (err_f) chk("err_no_valid", OUT_VALID, 1'b0);
      if (OUT_VALID && OUT_READY) begin
        chk("out_data", OUT_DATA, word(outs));
        chk("out_last", OUT_LAST, (outs == v.exp_beats - 1));
        if (outs == v.exp_beats - 1) leave_cyc = cyc;
        outs++;
      end
      if (CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN) begin
        if (!err_f) begin
          pend      = 1;
          pend_word = word(acc);
        end
        acc++;
      end
      if (CHNL_RX_ACK) ack_prev = 1;
      if (ends + errs > 0) tail++;
      if (tail > (v.hold ? 10 : 4)) done = 1;
      cyc++;
      if (!done && cyc > budget) begin
        n_cmp++;
        n_fail++;
        $display("FAIL timeout len=%0d: no frame completion within %0d cycles", v.len, budget);
        done = 1;
      end
    end
    CHNL_RX            = 1'b0;
    CHNL_RX_DATA_VALID = 1'b0;
    chk("ack_cycles", acks, 1);
    chk("accepted_beats", acc, v.exp_beats);
    chk("out_beats", outs, err_f ? 0 : v.exp_beats);
    chk("frame_end_count", ends, v.exp_end);
    chk("frame_err_count", errs, v.exp_err);
    if (!err_f && v.len == 32'd0) chk("end_after_ack", end_cyc - ack_cyc, 2);
    if (!err_f && v.len != 32'd0) chk("end_after_leave", end_cyc - leave_cyc, 3);
  endtask

  initial begin
    int acc, k, pulses;
    vecs[0] = '{32'd8,    0, 1'b0, 4,    1, 0};
    vecs[1] = '{32'd5,    1, 1'b0, 3,    1, 0};
    vecs[2] = '{32'd0,    0, 1'b0, 0,    1, 0};
    vecs[3] = '{32'd4098, 0, 1'b0, 2049, 0, 1};
    vecs[4] = '{32'd1,    2, 1'b0, 1,    1, 0};
    vecs[5] = '{32'd4096, 1, 1'b0, 2048, 1, 0};
    vecs[6] = '{32'd4097, 2, 1'b0, 2049, 0, 1};
    vecs[7] = '{32'd7,    2, 1'b0, 4,    1, 0};
    vecs[8] = '{32'd2,    0, 1'b1, 1,    1, 0};
    vecs[9] = '{32'd3,    1, 1'b0, 2,    1, 0};

    RST_N              = 1'b0;
    CHNL_RX            = 1'b0;
    CHNL_RX_LAST       = 1'b0;
    CHNL_RX_LEN        = 32'd0;
    CHNL_RX_OFF        = 31'd0;
    CHNL_RX_DATA       = 64'hDEAD_BEEF_0123_4567;
    CHNL_RX_DATA_VALID = 1'b1;
    OUT_READY          = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ack", CHNL_RX_ACK, 1'b0);
    chk("rst_ren", CHNL_RX_DATA_REN, 1'b0);
    chk("rst_valid", OUT_VALID, 1'b0);
    chk("rst_last", OUT_LAST, 1'b0);
    chk("rst_end", FRAME_END, 1'b0);
    chk("rst_err", FRAME_ERR, 1'b0);
    chk("rst_data", OUT_DATA, 64'd0);
    chk("rx_clk", CHNL_RX_CLK, CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 10; i++) run_frame(vecs[i]);

    // Reset after the second accepted beat of an 8-word frame.
    CHNL_RX = 1'b0;
    repeat (2) @(negedge CLK);
    acc = 0;
    k   = 0;
    while (acc < 2 && k < 40) begin
      @(negedge CLK);
      CHNL_RX            = 1'b1;
      CHNL_RX_LEN        = 32'd8;
      CHNL_RX_DATA       = word(acc);
      CHNL_RX_DATA_VALID = 1'b1;
      OUT_READY          = 1'b1;
      #1;
      if (CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN) acc++;
      k++;
    end
    chk("midrst_beats_before_reset", acc, 2);
    @(negedge CLK);
    RST_N   = 1'b0;
    CHNL_RX = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("midrst_ack", CHNL_RX_ACK, 1'b0);
    chk("midrst_ren", CHNL_RX_DATA_REN, 1'b0);
    chk("midrst_valid", OUT_VALID, 1'b0);
    chk("midrst_last", OUT_LAST, 1'b0);
    chk("midrst_end", FRAME_END, 1'b0);
    chk("midrst_err", FRAME_ERR, 1'b0);
    chk("midrst_data", OUT_DATA, 64'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      #1;
      if (FRAME_END || FRAME_ERR) pulses++;
    end
    chk("midrst_no_pulse", pulses, 0);
    run_frame('{32'd2, 0, 1'b0, 1, 1, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
